vga_text_render: RTL and testbench
==================================

# vga_text_render

Text-mode pixel renderer that sits directly downstream of the VGA timing generator, driven by its sync, enable, frame and coordinate outputs. It maps each active pixel to an 8×16 character cell and fetches the character/attribute word from external text RAM. It then fetches the glyph row from external font ROM, overlays a blinking underline cursor, and converts the result to 12-bit RGB through a 16-entry palette. Syncs and data enable are delayed so they stay aligned with the colour output for the display PHY.

## Interface
- COORD_WIDTH, 16, width of the signed screen coordinates
- COLS, 80, character columns
- ROWS, 30, character rows
- H_POL, 0, hsync active level; inactive level is ~H_POL
- V_POL, 0, vsync active level; inactive level is ~V_POL
- BLINK_LOG2, 5, cursor half-period is 2**BLINK_LOG2 frames
- clk_pixel  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- in_hsync, in_vsync  in  1  syncs from the timing generator
- in_de, in_frame  in  1  data enable and frame-start pulse
- screen_x, screen_y  in  COORD_WIDTH signed  current pixel; negative values are blanking
- text_addr  out  12  text RAM word address; row*COLS+col
- text_data  in  16  {attr[7:0], char[7:0]}, attr = {bg[3:0], fg[3:0]}; valid 1 cycle after text_addr
- font_addr  out  12  {char[7:0], glyph_row[3:0]}
- font_data  in  8  glyph row, bit 7 = leftmost pixel; valid 1 cycle after font_addr
- cursor_en  in  1  cursor display enable
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- out_hsync, out_vsync, out_de  out  1  syncs and enable delayed to match RGB
- out_r, out_g, out_b  out  4  pixel colour

## Operation
- S0, the input cycle: col = screen_x>>3, row = screen_y>>4, px = screen_x[2:0], gy = screen_y[3:0].
  - in_cell is asserted when in_de=1, 0≤col<COLS and 0≤row<ROWS.
  - text_addr is registered from row*COLS+col when in_cell, else 0.
- S1, the text RAM return: font_addr is registered from {text_data[7:0], gy}. fg, bg, px, gy, in_cell and the cursor hit are carried forward.
  - Cursor hit = cursor_en & col==cursor_col & row==cursor_row & gy≥14 & blink_on.
- S2, the font return: pixel_on = font_data[7-px] | cursor_hit; idx = pixel_on ? fg : bg.
- S3, the output stage: {out_r,out_g,out_b} is registered from PALETTE[idx] when in_cell, else 12'h000.
- Blink counter:
  - Width BLINK_LOG2+1; increments on every in_frame pulse and wraps naturally.
  - blink_on = ~counter[MSB].
- Sync and enable: in_hsync, in_vsync and in_de pass through a shift register matched to the RGB latency.

## Timing
- Latency: a pixel presented at cycle N appears on out_* at N+4. This applies equally to RGB, out_de, out_hsync and out_vsync.
- Reset values (asynchronous): out_hsync=~H_POL, out_vsync=~V_POL, out_de=0, RGB=0, text_addr=0, font_addr=0, blink counter=0 (cursor visible).
- Reset mid-frame: all pipeline stages flush to reset values. The first valid output appears 4 cycles after rst_n deasserts, with no glitch pulses on the syncs.
- Blanking and out-of-grid pixels (negative coordinates, col≥COLS, row≥ROWS) output black. out_de still follows in_de.
- in_frame coincident with an active pixel: impossible from the timing source. If it occurs anyway, the counter still increments and the pixel renders normally.
- Blink change takes effect on the pixel following the frame pulse; no mid-frame tearing.
- Cursor row/column inputs are sampled per pixel at S0; the RAM ports have no handshake and are read every cycle.

## Structure
- Package vga_text_pkg holds:
  - CELL_W=8 and CELL_H=16.
  - typedef text_word_t, a packed struct with bg, fg and char fields.
  - typedef rgb12_t.
  - PALETTE, a 16×rgb12_t CGA table: 0=000, 1=00A, 7=AAA, 12=F55, 15=FFF.
- Sub-module vga_delay_line, parameterised on WIDTH and DEPTH with a reset value per bit, carries the sync/enable alignment.

## Test plan
- Reset held mid-line and then released: out_hsync=1 and out_vsync=1 (POL=0) and RGB=0 while held; the first aligned pixel emerges exactly 4 cycles after release.
- screen_x=9, screen_y=17: text_addr=81. With text_data=16'h1F41, font_addr=12'h411; with font_data=8'b0100_0000 the output is px=1 → fg 15 → FFF at N+4.
- Same cell with font_data=0: bg 1 → 00A.
- screen_x=-5 with in_de=0: text_addr=0, RGB=000, out_de=0, and out_hsync tracks in_hsync delayed by 4.
- Cursor at col 0, row 0, cursor_en=1, gy=15, font_data=0, attr 8'h07:
  - After reset the output is AAA.
  - After 32 in_frame pulses the output is 000.
  - After 64 pulses the output is AAA again.
- screen_y=480 (row 30 ≥ ROWS) with in_de forced to 1: RGB=000, text_addr=0.

Source files
------------

// File: rtl/vga_text_pkg.sv
// -----------------------------------------------------------------------------
// vga_text_pkg
// Shared types and constants for the text-mode renderer.
//   CELL_W / CELL_H   : character cell geometry in pixels (8x16)
//   text_word_t       : text RAM word {bg, fg, ch}
//   rgb12_t           : 4:4:4 pixel colour
//   PALETTE           : 16-entry CGA colour table indexed by a 4-bit attribute
// -----------------------------------------------------------------------------
package vga_text_pkg;

    localparam int CELL_W      = 8;
    localparam int CELL_H      = 16;
    localparam int CELL_W_LOG2 = $clog2(CELL_W);
    localparam int CELL_H_LOG2 = $clog2(CELL_H);

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] ch;
    } text_word_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // Standard CGA palette; entry 6 is the brown variant (A50), not dark yellow.
    localparam rgb12_t PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    function automatic rgb12_t palette_lookup(input logic [3:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Fixed-depth shift register used to keep syncs/enable aligned with the
// rendered colour. Every stage resets to RST_VAL so that sync outputs sit at
// their inactive level during and right after reset.
//   clk_pixel : pixel clock
//   rst_n     : asynchronous active-low reset
//   d         : WIDTH-bit input sample
//   q         : d delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_pixel,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            stage <= {DEPTH{RST_VAL}};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_text_render.sv
// -----------------------------------------------------------------------------
// vga_text_render
// Text-mode pixel renderer placed after the VGA timing generator. Each active
// pixel is mapped to an 8x16 cell, the character/attribute word is read from
// text RAM, the glyph row from font ROM, a blinking underline cursor is
// overlaid and the result is coloured through a 16-entry palette.
//
// Pipeline (pixel presented in cycle N appears on out_* after the edge that
// ends cycle N+3, i.e. 4 registers):
//   S0 (N)   : cell decode, text_addr registered
//   S1 (N+1) : text_data valid, font_addr registered
//   S2 (N+2) : font_data valid, palette index registered
//   S3 (N+3) : colour registered
//
// Ports:
//   clk_pixel, rst_n                 : pixel clock, async active-low reset
//   in_hsync, in_vsync, in_de        : timing generator syncs / data enable
//   in_frame                         : frame-start pulse (advances cursor blink)
//   screen_x, screen_y               : signed pixel coordinate, negative = blank
//   text_addr / text_data            : text RAM port, data valid the cycle after
//                                      the address is computed
//   font_addr / font_data            : font ROM port, same timing
//   cursor_en, cursor_col, cursor_row: underline cursor control
//   out_hsync, out_vsync, out_de     : delayed syncs / enable
//   out_r, out_g, out_b              : 4:4:4 colour
// -----------------------------------------------------------------------------
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter int COORD_WIDTH = 16,
    parameter int COLS        = 80,
    parameter int ROWS        = 30,
    parameter bit H_POL       = 1'b0,
    parameter bit V_POL       = 1'b0,
    parameter int BLINK_LOG2  = 5
) (
    input  logic                          clk_pixel,
    input  logic                          rst_n,
    input  logic                          in_hsync,
    input  logic                          in_vsync,
    input  logic                          in_de,
    input  logic                          in_frame,
    input  logic signed [COORD_WIDTH-1:0] screen_x,
    input  logic signed [COORD_WIDTH-1:0] screen_y,
    output logic [11:0]                   text_addr,
    input  logic [15:0]                   text_data,
    output logic [11:0]                   font_addr,
    input  logic [7:0]                    font_data,
    input  logic                          cursor_en,
    input  logic [6:0]                    cursor_col,
    input  logic [4:0]                    cursor_row,
    output logic                          out_hsync,
    output logic                          out_vsync,
    output logic                          out_de,
    output logic [3:0]                    out_r,
    output logic [3:0]                    out_g,
    output logic [3:0]                    out_b
);

    localparam int STAGES = 4;

    // ---------------- blink counter ----------------
    logic [BLINK_LOG2:0] blink_cnt;
    logic                blink_on;

    // Counts every in_frame cycle regardless of in_de; the new value is seen
    // by the pixel after the pulse, so a frame never tears mid-way.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) blink_cnt <= '0;
        else if (in_frame) blink_cnt <= blink_cnt + 1'b1;
    end

    assign blink_on = ~blink_cnt[BLINK_LOG2];

    // ---------------- S0: cell decode ----------------
    logic signed [COORD_WIDTH-1:0] col_s, row_s;
    logic [2:0]                    px_c;
    logic [3:0]                    gy_c;
    logic                          in_cell;
    logic                          cursor_hit_c;
    logic [11:0]                   addr_c;

    assign col_s = screen_x >>> CELL_W_LOG2;
    assign row_s = screen_y >>> CELL_H_LOG2;
    assign px_c  = screen_x[2:0];
    assign gy_c  = screen_y[3:0];

    // Sign bits are checked explicitly, so the range compare can be unsigned.
    assign in_cell = in_de
                   & ~col_s[COORD_WIDTH-1] & ~row_s[COORD_WIDTH-1]
                   & ($unsigned(col_s) < COORD_WIDTH'(COLS))
                   & ($unsigned(row_s) < COORD_WIDTH'(ROWS));

    assign addr_c = in_cell ? 12'(12'(row_s) * 12'(COLS) + 12'(col_s)) : 12'd0;

    // in_cell guarantees col/row fit the narrow cursor compare widths.
    // The underline covers the two bottom glyph rows.
    assign cursor_hit_c = cursor_en & in_cell
                        & (col_s[6:0] == cursor_col)
                        & (row_s[4:0] == cursor_row)
                        & (gy_c >= 4'd14)
                        & blink_on;

    // Per-stage cell-valid bits; stage k holds the pixel's in_cell after k edges.
    logic [STAGES-1:1] vld_pipe;
    logic [2:0]        px1, px2;
    logic [3:0]        gy1;
    logic              cur1, cur2;
    logic [3:0]        fg2, bg2, idx3;
    rgb12_t            rgb_q;
    text_word_t        tw;

    assign tw = text_word_t'(text_data);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            text_addr <= '0;
            px1       <= '0;
            gy1       <= '0;
            cur1      <= 1'b0;
            font_addr <= '0;
            px2       <= '0;
            cur2      <= 1'b0;
            fg2       <= '0;
            bg2       <= '0;
            idx3      <= '0;
            rgb_q     <= '0;
        end else begin
            // S0 -> S1
            vld_pipe[1] <= in_cell;
            text_addr   <= addr_c;
            px1         <= px_c;
            gy1         <= gy_c;
            cur1        <= cursor_hit_c;
            // S1 -> S2: text word returned
            vld_pipe[2] <= vld_pipe[1];
            font_addr   <= {tw.ch, gy1};
            px2         <= px1;
            cur2        <= cur1;
            fg2         <= tw.fg;
            bg2         <= tw.bg;
            // S2 -> S3: glyph returned; bit 7 is leftmost, so index with ~px (7-px)
            vld_pipe[3] <= vld_pipe[2];
            idx3        <= (font_data[~px2] | cur2) ? fg2 : bg2;
            // S3 -> out
            rgb_q       <= vld_pipe[3] ? palette_lookup(idx3) : rgb12_t'(12'h000);
        end
    end

    assign out_r = rgb_q.r;
    assign out_g = rgb_q.g;
    assign out_b = rgb_q.b;

    // ---------------- sync / enable alignment ----------------
    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (STAGES),
        .RST_VAL ({~V_POL, ~H_POL, 1'b0})
    ) u_sync_dly (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .d         ({in_vsync, in_hsync, in_de}),
        .q         ({out_vsync, out_hsync, out_de})
    );

endmodule

// File: tb/tb_vga_text_render.sv
// -----------------------------------------------------------------------------
// tb_vga_text_render
// Directed vectors with hand-computed expectations. Text RAM and font ROM are
// modelled as bench-driven words returned in the cycle after the address.
// -----------------------------------------------------------------------------
module tb_vga_text_render;

    logic               clk_pixel = 1'b0;
    logic               rst_n;
    logic               in_hsync, in_vsync, in_de, in_frame;
    logic signed [15:0] screen_x, screen_y;
    logic [11:0]        text_addr, font_addr;
    logic [15:0]        text_data;
    logic [7:0]         font_data;
    logic               cursor_en;
    logic [6:0]         cursor_col;
    logic [4:0]         cursor_row;
    logic               out_hsync, out_vsync, out_de;
    logic [3:0]         out_r, out_g, out_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_pixel = ~clk_pixel;

    vga_text_render dut (
        .clk_pixel  (clk_pixel),
        .rst_n      (rst_n),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .in_de      (in_de),
        .in_frame   (in_frame),
        .screen_x   (screen_x),
        .screen_y   (screen_y),
        .text_addr  (text_addr),
        .text_data  (text_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .out_de     (out_de),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step one pixel clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    logic [11:0] rgb;
    assign rgb = {out_r, out_g, out_b};

    logic [11:0] hpat;

    initial begin
        rst_n      = 1'b0;
        in_hsync   = 1'b0;
        in_vsync   = 1'b0;
        in_de      = 1'b1;
        in_frame   = 1'b0;
        screen_x   = 16'sd9;
        screen_y   = 16'sd17;
        text_data  = 16'h1F41;
        font_data  = 8'b0100_0000;
        cursor_en  = 1'b0;
        cursor_col = '0;
        cursor_row = '0;

        // ---- reset held mid-line with active syncs on the inputs ----
        tick(3);
        chk("rst_hsync", out_hsync, 1);
        chk("rst_vsync", out_vsync, 1);
        chk("rst_de", out_de, 0);
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_taddr", text_addr, 0);
        chk("rst_faddr", font_addr, 0);

        // ---- release: constant active pixel (9,17), syncs inactive ----
        in_hsync = 1'b1;
        in_vsync = 1'b1;
        rst_n    = 1'b1;
        tick(1);
        chk("rel_taddr", text_addr, 81);
        chk("rel_hsync1", out_hsync, 1);
        tick(1);
        chk("rel_faddr", font_addr, 12'h411);
        chk("rel_hsync2", out_hsync, 1);
        tick(1);
        chk("rel_de3", out_de, 0);
        chk("rel_rgb3", rgb, 12'h000);
        tick(1);
        chk("rel_de4", out_de, 1);
        chk("fg_pixel", rgb, 12'hFFF);
        chk("rel_vsync4", out_vsync, 1);

        // ---- same cell, glyph row empty -> background ----
        font_data = 8'h00;
        tick(4);
        chk("bg_pixel", rgb, 12'h00A);

        // px=0 reads bit 7 (clear in 0100_0000) -> background
        font_data = 8'b0100_0000;
        screen_x  = 16'sd8;
        tick(4);
        chk("px0_bg", rgb, 12'h00A);

        // ---- blanking at x=-5, hsync pattern delayed by 4 ----
        screen_x = -16'sd5;
        in_de    = 1'b0;
        hpat     = 12'b1011_0010_0110;
        for (int i = 0; i < 12; i++) begin
            in_hsync = hpat[i];
            tick(1);
            if (i >= 3) begin
                chk("blank_hsync", out_hsync, hpat[i-3]);
                chk("blank_rgb", rgb, 12'h000);
                chk("blank_de", out_de, 0);
                chk("blank_taddr", text_addr, 0);
            end
        end
        in_hsync = 1'b1;

        // ---- out-of-grid row 30 with in_de forced high ----
        screen_x = 16'sd9;
        screen_y = 16'sd480;
        in_de    = 1'b1;
        tick(1);
        chk("row30_taddr", text_addr, 0);
        tick(3);
        chk("row30_rgb", rgb, 12'h000);
        chk("row30_de", out_de, 1);

        // column 80 is also outside the grid
        screen_x = 16'sd640;
        screen_y = 16'sd17;
        tick(4);
        chk("col80_rgb", rgb, 12'h000);

        // last cell (79,29): address 2399
        screen_x = 16'sd639;
        screen_y = 16'sd479;
        tick(1);
        chk("last_taddr", text_addr, 2399);

        // ---- cursor at (0,0), attr 07, empty glyph ----
        cursor_en = 1'b1;
        text_data = 16'h0741;
        font_data = 8'h00;
        screen_x  = 16'sd3;
        screen_y  = 16'sd15;
        tick(4);
        chk("cur_on_reset", rgb, 12'hAAA);

        screen_y = 16'sd13;
        tick(4);
        chk("cur_gy13", rgb, 12'h000);
        screen_y = 16'sd14;
        tick(4);
        chk("cur_gy14", rgb, 12'hAAA);
        screen_y = 16'sd15;

        // cursor on a different column is not drawn
        cursor_col = 7'd1;
        tick(4);
        chk("cur_other_col", rgb, 12'h000);
        cursor_col = 7'd0;

        in_frame = 1'b1;
        tick(31);
        in_frame = 1'b0;
        tick(4);
        chk("cur_31frames", rgb, 12'hAAA);

        in_frame = 1'b1;
        tick(1);
        in_frame = 1'b0;
        tick(4);
        chk("cur_32frames", rgb, 12'h000);

        in_frame = 1'b1;
        tick(32);
        in_frame = 1'b0;
        tick(4);
        chk("cur_64frames", rgb, 12'hAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
